encoder_fec_conv: RTL and testbench



---
 rtl/encoder_fec_conv_pkg.sv | 21 ++
 rtl/encoder_fec_conv_core.sv | 35 +++
 rtl/encoder_fec_conv.sv | 178 +++++++++++++++++
 tb/tb_encoder_fec_conv.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_fec_conv_pkg.sv
// Shared types and constants for the K=7 rate-1/2 convolutional encoder.
// No logic here; latency and backpressure live in the modules.
package encoder_fec_pck;

  localparam int CONV_K = 7;
  localparam int CONV_TAIL = CONV_K - 1;
  localparam logic [CONV_K-1:0] CONV_G0 = 7'b1111001;
  localparam logic [CONV_K-1:0] CONV_G1 = 7'b1011011;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    TAIL  = 3'd4,
    DONE  = 3'd5
  } conv_state_e;

  typedef logic [1:0] sym_t;

endpackage

// File: rtl/encoder_fec_conv_core.sv
// Generator core: {c0,c1} is combinational from {b, s}; s shifts one bit per
// advance strobe, so the caller controls backpressure by withholding i_adv.
module conv_core_k7
  import encoder_fec_pck::*;
#(
  parameter int K = CONV_K,
  parameter logic [K-1:0] G0 = CONV_G0,
  parameter logic [K-1:0] G1 = CONV_G1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_adv,
  input  logic i_b,
  output sym_t o_sym
);

  logic [K-2:0] r_s;
  logic [K-1:0] w_win;

  // r_s[K-2] is the most recent past bit, so the window lines up with the MSB tap.
  assign w_win = {i_b, r_s};
  assign o_sym = {^(w_win & G0), ^(w_win & G1)};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s <= '0;
    end else if (i_clr) begin
      r_s <= '0;
    end else if (i_adv) begin
      r_s <= {i_b, r_s[K-2:1]};
    end
  end

endmodule

// File: rtl/encoder_fec_conv.sv
// Frame-level FEC encoder: fetches bytes (2-cycle fetch), emits one symbol per cycle plus K-1 tail symbols.
// Symbols hold under !sym_ready; en=0 lets a presented symbol finish but starts nothing new.
module encoder_fec_conv
  import encoder_fec_pck::*;
#(
  parameter int DATA_W = 8,
  parameter int K = CONV_K,
  parameter logic [K-1:0] G0 = CONV_G0,
  parameter logic [K-1:0] G1 = CONV_G1,
  parameter int FRAME_BYTES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              req,
  output logic              ack,
  input  logic              buff_empty,
  output logic              rd_en_buff,
  input  logic [DATA_W-1:0] rd_data,
  output logic              sym_valid,
  output logic [1:0]        sym_data,
  input  logic              sym_ready,
  output logic              busy
);

  localparam int LP_BW = $clog2(DATA_W);
  localparam int LP_TW = $clog2(K);
  localparam logic [LP_BW-1:0] LP_LAST_BIT = LP_BW'(DATA_W - 1);
  localparam logic [LP_TW-1:0] LP_LAST_TAIL = LP_TW'(K - 2);
  localparam logic [15:0] LP_LAST_BYTE = 16'(FRAME_BYTES - 1);

  conv_state_e r_state;
  conv_state_e w_nxt;

  logic [DATA_W-1:0] r_byte_reg;
  logic [LP_BW-1:0]  r_bit_cnt;
  logic [15:0]       r_byte_cnt;
  logic [LP_TW-1:0]  r_tail_cnt;
  logic              r_busy;
  logic              r_armed;
  logic              r_hold;

  logic w_rd;
  logic w_valid;
  logic w_accept;
  logic w_start;
  logic w_ack;
  logic w_b;
  logic w_last_bit;
  logic w_last_byte;
  logic w_last_tail;
  sym_t w_sym;

  assign w_last_bit  = (r_bit_cnt == LP_LAST_BIT);
  assign w_last_byte = (r_byte_cnt == LP_LAST_BYTE);
  assign w_last_tail = (r_tail_cnt == LP_LAST_TAIL);
  assign w_b         = (r_state == SHIFT) ? r_byte_reg[DATA_W-1] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  // r_hold keeps a presented-but-unaccepted symbol valid even if en drops.
  always_comb begin
    w_nxt    = r_state;
    w_rd     = 1'b0;
    w_valid  = 1'b0;
    w_accept = 1'b0;
    w_start  = 1'b0;
    w_ack    = 1'b0;
    case (r_state)
      IDLE: begin
        if (en && req && r_armed) begin
          w_start = 1'b1;
          w_nxt   = FETCH;
        end
      end
      FETCH: begin
        if (en && !buff_empty) begin
          w_rd  = 1'b1;
          w_nxt = LOAD;
        end
      end
      LOAD: begin
        w_nxt = SHIFT;
      end
      SHIFT: begin
        w_valid = en | r_hold;
        if (w_valid && sym_ready) begin
          w_accept = 1'b1;
          if (w_last_bit) begin
            w_nxt = w_last_byte ? TAIL : FETCH;
          end
        end
      end
      TAIL: begin
        w_valid = en | r_hold;
        if (w_valid && sym_ready) begin
          w_accept = 1'b1;
          if (w_last_tail) begin
            w_nxt = DONE;
          end
        end
      end
      DONE: begin
        w_ack = 1'b1;
        w_nxt = IDLE;
      end
      default: begin
        w_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_reg <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_tail_cnt <= '0;
      r_busy     <= 1'b0;
      r_armed    <= 1'b1;
      r_hold     <= 1'b0;
    end else begin
      r_hold <= w_valid & ~sym_ready;
      if (w_start) begin
        r_byte_cnt <= '0;
        r_busy     <= 1'b1;
      end
      if (r_state == LOAD) begin
        r_byte_reg <= rd_data;
        r_bit_cnt  <= '0;
      end
      // The byte register shifts left so the next input bit is always its MSB.
      if (w_accept && (r_state == SHIFT)) begin
        r_byte_reg <= {r_byte_reg[DATA_W-2:0], 1'b0};
        r_bit_cnt  <= r_bit_cnt + LP_BW'(1);
        if (w_last_bit) begin
          r_byte_cnt <= r_byte_cnt + 16'd1;
          r_tail_cnt <= '0;
        end
      end
      if (w_accept && (r_state == TAIL)) begin
        r_tail_cnt <= r_tail_cnt + LP_TW'(1);
      end
      if (w_ack) begin
        r_busy  <= 1'b0;
        r_armed <= 1'b0;
      end else if (!req) begin
        r_armed <= 1'b1;
      end
    end
  end

  conv_core_k7 #(
    .K  (K),
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_start),
    .i_adv (w_accept),
    .i_b   (w_b),
    .o_sym (w_sym)
  );

  assign ack        = w_ack;
  assign rd_en_buff = w_rd;
  assign sym_valid  = w_valid;
  assign sym_data   = w_valid ? w_sym : 2'b00;
  assign busy       = r_busy;

endmodule

// File: tb/tb_encoder_fec_conv.sv
// Bench for encoder_fec_conv: random frames checked against a bit-history model of the code.
module tb_encoder_fec_conv;

  localparam int FB = 2;
  localparam logic [6:0] TG0 = 7'o171;
  localparam logic [6:0] TG1 = 7'o133;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       req = 1'b0;
  logic       ack;
  logic       buff_empty = 1'b1;
  logic       rd_en_buff;
  logic [7:0] rd_data = 8'h00;
  logic       sym_valid;
  logic [1:0] sym_data;
  logic       sym_ready = 1'b0;
  logic       busy;

  always #5 clk = ~clk;

  encoder_fec_conv #(
    .DATA_W      (8),
    .FRAME_BYTES (FB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req        (req),
    .ack        (ack),
    .buff_empty (buff_empty),
    .rd_en_buff (rd_en_buff),
    .rd_data    (rd_data),
    .sym_valid  (sym_valid),
    .sym_data   (sym_data),
    .sym_ready  (sym_ready),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_total = 0;
  int served = 0;
  int ready_mode = 0;
  int stab_err = 0;
  int stall_cnt = 0;
  logic prev_stall = 1'b0;
  logic [1:0] prev_dat = 2'b00;

  logic [7:0] buf_q[$];
  logic [1:0] got_q[$];
  logic [1:0] exp_q[$];
  int acc_cyc[$];
  int rd_cyc[$];
  int ack_cyc[$];

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rd_en_buff) begin
      rd_cyc.push_back(cyc);
      rd_total++;
    end
    if (ack) ack_cyc.push_back(cyc);
    if (prev_stall && (!sym_valid || sym_data !== prev_dat)) stab_err++;
    if (sym_valid && sym_ready) begin
      got_q.push_back(sym_data);
      acc_cyc.push_back(cyc);
    end
    prev_stall = sym_valid && !sym_ready;
    if (prev_stall) stall_cnt++;
    prev_dat = sym_data;
  end

  // TX buffer and modulator ready model.
  always @(posedge clk) begin
    #2;
    if (served < rd_total) begin
      rd_data = (buf_q.size() > 0) ? buf_q.pop_front() : 8'hEE;
      served++;
    end
    buff_empty = (buf_q.size() == 0);
    case (ready_mode)
      0: sym_ready = 1'b1;
      1: sym_ready = (cyc % 3 == 0);
      default: sym_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int to);
    int n;
    int a0;
    n = 0;
    a0 = ack_cyc.size();
    while (ack_cyc.size() == a0 && n < 600) begin
      tick(1);
      n++;
    end
    to = (n >= 600) ? 1 : 0;
  endtask

  task automatic wait_syms(input int target, output int to);
    int n;
    n = 0;
    while (got_q.size() < target && n < 300) begin
      tick(1);
      n++;
    end
    to = (n >= 300) ? 1 : 0;
  endtask

  // Each symbol is the parity of the generator taps over the last 7 input bits.
  task automatic build_exp(input logic [7:0] b0, input logic [7:0] b1);
    logic bits[$];
    logic [7:0] bytes[2];
    logic c0;
    logic c1;
    bytes[0] = b0;
    bytes[1] = b1;
    exp_q.delete();
    for (int k = 0; k < FB; k++)
      for (int i = 7; i >= 0; i--) bits.push_back(bytes[k][i]);
    for (int i = 0; i < 6; i++) bits.push_back(1'b0);
    for (int n = 0; n < bits.size(); n++) begin
      c0 = 1'b0;
      c1 = 1'b0;
      for (int j = 0; j < 7; j++) begin
        if (n - j >= 0) begin
          c0 = c0 ^ (TG0[6-j] & bits[n-j]);
          c1 = c1 ^ (TG1[6-j] & bits[n-j]);
        end
      end
      exp_q.push_back({c0, c1});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
    checks++; if (rd_en_buff !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", rd_en_buff); end
    checks++; if (sym_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", sym_valid); end
    checks++; if (sym_data !== 2'b00) begin errors++; $display("FAIL reset_data: got %b expected 00", sym_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tick(1);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_impulse();
    int g0, r0, a0, to;
    logic [1:0] imp[7];
    imp = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
    ready_mode = 0;
    build_exp(8'h80, 8'h00);
    g0 = got_q.size(); r0 = rd_cyc.size(); a0 = ack_cyc.size();
    buf_q.push_back(8'h80); buf_q.push_back(8'h00);
    req = 1'b1;
    wait_ack(to);
    req = 1'b0;
    tick(2);
    checks++; if (to != 0) begin errors++; $display("FAIL impulse_timeout: got no ack expected ack"); end
    checks++; if (int'(got_q.size()) - g0 != 22) begin errors++; $display("FAIL impulse_count: got %0d expected 22", int'(got_q.size()) - g0); end
    for (int i = 0; i < 22; i++) if (g0 + i < got_q.size()) begin
      checks++; if (got_q[g0+i] !== exp_q[i]) begin errors++; $display("FAIL impulse_sym[%0d]: got %b expected %b", i, got_q[g0+i], exp_q[i]); end
    end
    for (int i = 0; i < 7; i++) if (g0 + i < got_q.size()) begin
      checks++; if (got_q[g0+i] !== imp[i]) begin errors++; $display("FAIL impulse_resp[%0d]: got %b expected %b", i, got_q[g0+i], imp[i]); end
    end
    if (ack_cyc.size() > a0 && acc_cyc.size() > 0) begin
      checks++; if (ack_cyc[a0] != acc_cyc[acc_cyc.size()-1] + 1) begin errors++; $display("FAIL impulse_ack_time: got cycle %0d expected %0d", ack_cyc[a0], acc_cyc[acc_cyc.size()-1] + 1); end
    end
    checks++; if (int'(ack_cyc.size()) - a0 != 1) begin errors++; $display("FAIL impulse_ack_count: got %0d expected 1", int'(ack_cyc.size()) - a0); end
    checks++; if (int'(rd_cyc.size()) - r0 != FB) begin errors++; $display("FAIL impulse_rd_count: got %0d expected %0d", int'(rd_cyc.size()) - r0, FB); end
  endtask

  task automatic test_zero_frame();
    int g0, r0, to;
    ready_mode = 0;
    g0 = got_q.size(); r0 = rd_cyc.size();
    buf_q.push_back(8'h00); buf_q.push_back(8'h00);
    req = 1'b1;
    wait_ack(to);
    req = 1'b0;
    tick(2);
    checks++; if (to != 0) begin errors++; $display("FAIL zero_timeout: got no ack expected ack"); end
    checks++; if (int'(got_q.size()) - g0 != 22) begin errors++; $display("FAIL zero_count: got %0d expected 22", int'(got_q.size()) - g0); end
    for (int i = g0; i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== 2'b00) begin errors++; $display("FAIL zero_sym[%0d]: got %b expected 00", i - g0, got_q[i]); end
    end
    checks++; if (int'(rd_cyc.size()) - r0 != 2) begin errors++; $display("FAIL zero_rd_count: got %0d expected 2", int'(rd_cyc.size()) - r0); end
    if (acc_cyc.size() >= g0 + 9 && rd_cyc.size() >= r0 + 2) begin
      checks++; if (acc_cyc[g0+7] != acc_cyc[g0] + 7) begin errors++; $display("FAIL zero_byte_rate: got %0d expected %0d", acc_cyc[g0+7], acc_cyc[g0] + 7); end
      checks++; if (rd_cyc[r0+1] != acc_cyc[g0+7] + 1) begin errors++; $display("FAIL zero_rd_time: got %0d expected %0d", rd_cyc[r0+1], acc_cyc[g0+7] + 1); end
      checks++; if (acc_cyc[g0+8] != acc_cyc[g0+7] + 3) begin errors++; $display("FAIL zero_byte_gap: got %0d expected %0d", acc_cyc[g0+8], acc_cyc[g0+7] + 3); end
    end
  endtask

  task automatic test_backpressure();
    int g0, s0, st0, to;
    ready_mode = 1;
    build_exp(8'h80, 8'h00);
    g0 = got_q.size(); s0 = stab_err; st0 = stall_cnt;
    buf_q.push_back(8'h80); buf_q.push_back(8'h00);
    req = 1'b1;
    wait_ack(to);
    req = 1'b0;
    tick(2);
    ready_mode = 0;
    checks++; if (to != 0) begin errors++; $display("FAIL bp_timeout: got no ack expected ack"); end
    checks++; if (int'(got_q.size()) - g0 != 22) begin errors++; $display("FAIL bp_count: got %0d expected 22", int'(got_q.size()) - g0); end
    for (int i = 0; i < 22; i++) if (g0 + i < got_q.size()) begin
      checks++; if (got_q[g0+i] !== exp_q[i]) begin errors++; $display("FAIL bp_sym[%0d]: got %b expected %b", i, got_q[g0+i], exp_q[i]); end
    end
    checks++; if (stab_err != s0) begin errors++; $display("FAIL bp_stable: got %0d violations expected 0", stab_err - s0); end
    checks++; if (stall_cnt == st0) begin errors++; $display("FAIL bp_stalls: got 0 stalled cycles expected nonzero"); end
  endtask

  task automatic test_underrun();
    int g0, r0, to, bad;
    logic [7:0] b0, b1;
    b0 = 8'($urandom); b1 = 8'($urandom);
    ready_mode = 0;
    build_exp(b0, b1);
    g0 = got_q.size(); r0 = rd_cyc.size(); bad = 0;
    buf_q.push_back(b0);
    req = 1'b1;
    wait_syms(g0 + 8, to);
    checks++; if (to != 0) begin errors++; $display("FAIL underrun_first_byte: got %0d symbols expected 8", int'(got_q.size()) - g0); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sym_valid || rd_en_buff) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL underrun_idle: got %0d active cycles expected 0", bad); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL underrun_busy: got %b expected 1", busy); end
    tick(1);
    buf_q.push_back(b1);
    wait_ack(to);
    req = 1'b0;
    tick(2);
    checks++; if (to != 0) begin errors++; $display("FAIL underrun_timeout: got no ack expected ack"); end
    checks++; if (int'(got_q.size()) - g0 != 22) begin errors++; $display("FAIL underrun_count: got %0d expected 22", int'(got_q.size()) - g0); end
    for (int i = 0; i < 22; i++) if (g0 + i < got_q.size()) begin
      checks++; if (got_q[g0+i] !== exp_q[i]) begin errors++; $display("FAIL underrun_sym[%0d]: got %b expected %b", i, got_q[g0+i], exp_q[i]); end
    end
    checks++; if (int'(rd_cyc.size()) - r0 != 2) begin errors++; $display("FAIL underrun_rd_count: got %0d expected 2", int'(rd_cyc.size()) - r0); end
    if (acc_cyc.size() >= g0 + 9) begin
      checks++; if (acc_cyc[g0+8] - acc_cyc[g0+7] < 12) begin errors++; $display("FAIL underrun_gap: got %0d cycles expected >= 12", acc_cyc[g0+8] - acc_cyc[g0+7]); end
    end
  endtask

  task automatic test_en_pause();
    int g0, gp, to, bad;
    logic [7:0] b0, b1;
    b0 = 8'($urandom); b1 = 8'($urandom);
    ready_mode = 0;
    build_exp(b0, b1);
    g0 = got_q.size(); bad = 0;
    buf_q.push_back(b0); buf_q.push_back(b1);
    req = 1'b1;
    wait_syms(g0 + 3, to);
    en = 1'b0;
    gp = got_q.size();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (sym_valid || rd_en_buff) bad++;
    end
    tick(1);
    checks++; if (bad != 0) begin errors++; $display("FAIL en_pause_idle: got %0d active cycles expected 0", bad); end
    checks++; if (got_q.size() != gp) begin errors++; $display("FAIL en_pause_accepts: got %0d expected %0d", got_q.size(), gp); end
    en = 1'b1;
    wait_ack(to);
    req = 1'b0;
    tick(2);
    checks++; if (to != 0) begin errors++; $display("FAIL en_pause_timeout: got no ack expected ack"); end
    checks++; if (int'(got_q.size()) - g0 != 22) begin errors++; $display("FAIL en_pause_count: got %0d expected 22", int'(got_q.size()) - g0); end
    for (int i = 0; i < 22; i++) if (g0 + i < got_q.size()) begin
      checks++; if (got_q[g0+i] !== exp_q[i]) begin errors++; $display("FAIL en_pause_sym[%0d]: got %b expected %b", i, got_q[g0+i], exp_q[i]); end
    end
  endtask

  task automatic test_held_req();
    int g0, r0, s0, to;
    logic [7:0] b0, b1;
    ready_mode = 2;
    b0 = 8'($urandom); b1 = 8'($urandom);
    build_exp(b0, b1);
    g0 = got_q.size(); s0 = stab_err;
    buf_q.push_back(b0); buf_q.push_back(b1);
    req = 1'b1;
    wait_ack(to);
    checks++; if (to != 0) begin errors++; $display("FAIL held_first_timeout: got no ack expected ack"); end
    for (int i = 0; i < 22; i++) if (g0 + i < got_q.size()) begin
      checks++; if (got_q[g0+i] !== exp_q[i]) begin errors++; $display("FAIL held_first_sym[%0d]: got %b expected %b", i, got_q[g0+i], exp_q[i]); end
    end
    b0 = 8'($urandom); b1 = 8'($urandom);
    buf_q.push_back(b0); buf_q.push_back(b1);
    g0 = got_q.size(); r0 = rd_cyc.size();
    tick(20);
    @(negedge clk);
    checks++; if (rd_cyc.size() != r0) begin errors++; $display("FAIL held_no_restart_rd: got %0d reads expected 0", int'(rd_cyc.size()) - r0); end
    checks++; if (got_q.size() != g0) begin errors++; $display("FAIL held_no_restart_sym: got %0d symbols expected 0", int'(got_q.size()) - g0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_busy: got %b expected 0", busy); end
    tick(1);
    req = 1'b0;
    tick(1);
    req = 1'b1;
    build_exp(b0, b1);
    wait_ack(to);
    req = 1'b0;
    tick(2);
    ready_mode = 0;
    checks++; if (to != 0) begin errors++; $display("FAIL held_second_timeout: got no ack expected ack"); end
    checks++; if (int'(got_q.size()) - g0 != 22) begin errors++; $display("FAIL held_second_count: got %0d expected 22", int'(got_q.size()) - g0); end
    for (int i = 0; i < 22; i++) if (g0 + i < got_q.size()) begin
      checks++; if (got_q[g0+i] !== exp_q[i]) begin errors++; $display("FAIL held_second_sym[%0d]: got %b expected %b", i, got_q[g0+i], exp_q[i]); end
    end
    checks++; if (stab_err != s0) begin errors++; $display("FAIL held_stable: got %0d violations expected 0", stab_err - s0); end
  endtask

  task automatic test_reset_mid();
    int g0, a0, to;
    ready_mode = 0;
    g0 = got_q.size();
    buf_q.push_back(8'h5A); buf_q.push_back(8'hC3);
    req = 1'b1;
    wait_syms(g0 + 18, to);
    checks++; if (to != 0) begin errors++; $display("FAIL rstmid_reach_tail: got %0d symbols expected 18", int'(got_q.size()) - g0); end
    a0 = ack_cyc.size();
    rst = 1'b1;
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if ({ack, rd_en_buff, sym_valid, sym_data, busy} !== 6'b0) begin errors++; $display("FAIL rstmid_outputs: got %b expected 000000", {ack, rd_en_buff, sym_valid, sym_data, busy}); end
    tick(1);
    rst = 1'b0;
    tick(10);
    checks++; if (ack_cyc.size() != a0) begin errors++; $display("FAIL rstmid_no_ack: got %0d acks expected 0", int'(ack_cyc.size()) - a0); end
    build_exp(8'h80, 8'h00);
    g0 = got_q.size();
    buf_q.push_back(8'h80); buf_q.push_back(8'h00);
    req = 1'b1;
    wait_ack(to);
    req = 1'b0;
    tick(2);
    checks++; if (to != 0) begin errors++; $display("FAIL rstmid_timeout: got no ack expected ack"); end
    checks++; if (int'(got_q.size()) - g0 != 22) begin errors++; $display("FAIL rstmid_count: got %0d expected 22", int'(got_q.size()) - g0); end
    for (int i = 0; i < 22; i++) if (g0 + i < got_q.size()) begin
      checks++; if (got_q[g0+i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_sym[%0d]: got %b expected %b", i, got_q[g0+i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    en = 1'b1;
    tick(2);
    test_impulse();
    test_zero_frame();
    test_backpressure();
    test_underrun();
    test_en_pause();
    test_held_req();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
